// File: rtl/apu_pkg.sv
// Shared definitions for the APU DMC sample-fetch DMA: state encoding and
// the default number of stolen CPU cycles ahead of the read.
package apu_pkg;

  localparam int unsigned STALL_CYC_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_STALL = 3'd2,
    ST_READ  = 3'd3,
    ST_DONE  = 3'd4
  } dma_state_e;

endpackage

// File: rtl/apu_dmc_dma.sv
// DMC sample-fetch DMA: halts the CPU, steals P_STALL_CYC cycles, then reads
// one byte over the system bus and hands it to the DMC with a one-clk grant.
//
// state | meaning
// IDLE  | no transfer, CPU runs
// HALT  | CPU halt requested, waiting for a CPU read cycle with OAM DMA idle
// STALL | committed, burning the remaining stolen cycles
// READ  | block owns the bus, sample captured on the next CPU cycle
// DONE  | one clk: grant (if still requested), CPU released
module apu_dmc_dma
  import apu_pkg::*;
#(
  parameter int unsigned P_STALL_CYC = STALL_CYC_DEF
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_cpu_ce,
  input  logic        i_dmc_req,
  input  logic [15:0] i_dmc_addr,
  output logic        o_dmc_gnt,
  output logic [7:0]  o_dmc_smpl,
  output logic        o_cpu_rdy,
  input  logic        i_cpu_wn,
  input  logic        i_oam_busy,
  output logic        o_bus_own,
  output logic [15:0] o_bus_addr,
  input  logic [7:0]  i_bus_rdata,
  output logic        o_busy
);

  localparam logic [2:0] CNT_LOAD = 3'(P_STALL_CYC - 1);

  dma_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] bus_addr_q, bus_addr_d;
  logic [7:0]  smpl_q, smpl_d;
  logic        accept;

  assign accept = i_cpu_ce & i_cpu_wn & ~i_oam_busy;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    bus_addr_d = bus_addr_q;
    smpl_d     = smpl_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_dmc_req) state_d = ST_HALT;
      end
      ST_HALT: begin
        // a dropped request wins over a same-clk accept: nothing is committed yet
        if (!i_dmc_req) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          addr_d = i_dmc_addr;
          cnt_d  = CNT_LOAD;
          if (CNT_LOAD == 3'd0) begin
            state_d    = ST_READ;
            bus_addr_d = i_dmc_addr;
          end else begin
            state_d = ST_STALL;
          end
        end
      end
      ST_STALL: begin
        if (i_cpu_ce) begin
          if (cnt_q == 3'd1) begin
            state_d    = ST_READ;
            cnt_d      = 3'd0;
            bus_addr_d = addr_q;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      ST_READ: begin
        if (i_cpu_ce) begin
          smpl_d  = i_bus_rdata;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      addr_q     <= 16'h0000;
      bus_addr_q <= 16'h0000;
      smpl_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      bus_addr_q <= bus_addr_d;
      smpl_q     <= smpl_d;
    end
  end

  assign o_dmc_gnt  = (state_q == ST_DONE) & i_dmc_req;
  assign o_dmc_smpl = smpl_q;
  assign o_cpu_rdy  = !((state_q == ST_HALT) || (state_q == ST_STALL) || (state_q == ST_READ));
  assign o_bus_own  = (state_q == ST_READ);
  assign o_bus_addr = bus_addr_q;
  assign o_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_apu_dmc_dma.sv
// Scoreboard bench for apu_dmc_dma: two instances (stall 3 and stall 1) share
// the CPU/bus inputs; expected samples are queued by the driver, popped on grant.
module tb_apu_dmc_dma;

  localparam int PV [2] = '{3, 1};

  logic        i_clk = 1'b0;
  logic        rstn;
  logic        ce, wn, oam;
  logic [15:0] dmc_addr;
  logic [7:0]  rdata;
  logic        req   [2];
  logic        gnt   [2];
  logic [7:0]  smpl  [2];
  logic        rdy   [2];
  logic        own   [2];
  logic [15:0] baddr [2];
  logic        busy  [2];

  logic [7:0]  exp_q0 [$];
  logic [7:0]  exp_q1 [$];

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 i_clk = ~i_clk;

  apu_dmc_dma #(.P_STALL_CYC(3)) u_dut0 (
    .i_clk(i_clk), .i_rstn(rstn), .i_cpu_ce(ce), .i_dmc_req(req[0]),
    .i_dmc_addr(dmc_addr), .o_dmc_gnt(gnt[0]), .o_dmc_smpl(smpl[0]),
    .o_cpu_rdy(rdy[0]), .i_cpu_wn(wn), .i_oam_busy(oam), .o_bus_own(own[0]),
    .o_bus_addr(baddr[0]), .i_bus_rdata(rdata), .o_busy(busy[0])
  );

  apu_dmc_dma #(.P_STALL_CYC(1)) u_dut1 (
    .i_clk(i_clk), .i_rstn(rstn), .i_cpu_ce(ce), .i_dmc_req(req[1]),
    .i_dmc_addr(dmc_addr), .o_dmc_gnt(gnt[1]), .o_dmc_smpl(smpl[1]),
    .o_cpu_rdy(rdy[1]), .i_cpu_wn(wn), .i_oam_busy(oam), .o_bus_own(own[1]),
    .o_bus_addr(baddr[1]), .i_bus_rdata(rdata), .o_busy(busy[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Monitor: every grant must match the oldest queued sample for that instance.
  always @(negedge i_clk) begin
    if (gnt[0] === 1'b1) begin
      check("gnt0_expected", exp_q0.size() != 0, 1);
      if (exp_q0.size() != 0) check("gnt0_smpl", smpl[0], exp_q0.pop_front());
    end
    if (gnt[1] === 1'b1) begin
      check("gnt1_expected", exp_q1.size() != 0, 1);
      if (exp_q1.size() != 0) check("gnt1_smpl", smpl[1], exp_q1.pop_front());
    end
    if (oam === 1'b1) begin
      check("own0_while_oam", own[0], 0);
      check("own1_while_oam", own[1], 0);
    end
  end

  task automatic check_reset(input int s);
    check("rst_gnt",   gnt[s],   0);
    check("rst_smpl",  smpl[s],  8'h00);
    check("rst_rdy",   rdy[s],   1);
    check("rst_own",   own[s],   0);
    check("rst_baddr", baddr[s], 16'h0000);
    check("rst_busy",  busy[s],  0);
  endtask

  // One fetch: nblk write/OAM cycles in HALT, then accept, P_STALL_CYC more cycles.
  // mode 0 random blocking, 1 writes, 2 OAM busy.
  task automatic run_xfer(input int s, input logic [15:0] a, input int nblk,
                          input int mode, input bit drop_stall, input bit keep);
    int         ntot;
    logic [7:0] d;
    logic [7:0] exp_smpl;
    logic       w, o;
    exp_smpl = 8'h00;
    dmc_addr = a;
    req[s]   = 1'b1;
    tick();
    check("halt_busy", busy[s], 1);
    check("halt_rdy", rdy[s], 0);
    ntot = nblk + PV[s] + 1;
    for (int j = 0; j < ntot; j++) begin
      d = 8'($urandom);
      if (j < nblk) begin
        case (mode)
          1: begin w = 1'b0; o = 1'b0; end
          2: begin w = 1'b1; o = 1'b1; end
          default: begin
            w = 1'($urandom_range(0, 1));
            o = w ? 1'b1 : 1'($urandom_range(0, 1));
          end
        endcase
      end else if (j == nblk) begin
        w = 1'b1; o = 1'b0;
      end else if (j == ntot - 1) begin
        w = 1'($urandom_range(0, 1)); o = 1'b0;
      end else begin
        w = 1'($urandom_range(0, 1)); o = 1'($urandom_range(0, 1));
      end
      if (drop_stall && j == nblk + 1) req[s] = 1'b0;
      wn = w; oam = o; rdata = d; ce = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      ce = 1'b1;
      check("stolen_rdy_low", rdy[s], 0);
      check("bus_own_read_only", own[s], j == ntot - 1);
      if (j == ntot - 1) check("bus_addr_read", baddr[s], a);
      exp_smpl = d;
      tick();
    end
    ce = 1'b0; oam = 1'b0;
    if (!drop_stall) begin
      if (s == 0) exp_q0.push_back(exp_smpl);
      else        exp_q1.push_back(exp_smpl);
    end
    check("done_rdy", rdy[s], 1);
    check("done_own", own[s], 0);
    check("done_gnt", gnt[s], !drop_stall);
    check("done_smpl", smpl[s], exp_smpl);
    tick();
    check("idle_busy", busy[s], 0);
    check("idle_rdy", rdy[s], 1);
    check("idle_addr_hold", baddr[s], a);
    check("idle_smpl_hold", smpl[s], exp_smpl);
    if (!keep) req[s] = 1'b0;
  endtask

  task automatic abort_halt(input int s);
    dmc_addr = 16'($urandom);
    req[s] = 1'b1;
    tick();
    wn = 1'b0; oam = 1'b0; ce = 1'b1;
    tick();
    ce = 1'b0;
    check("abort_still_halted", rdy[s], 0);
    req[s] = 1'b0;
    tick();
    check("abort_rdy", rdy[s], 1);
    check("abort_busy", busy[s], 0);
    check("abort_own", own[s], 0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  s, nxt_s;
    bit  drop, keep;
    logic [15:0] a;
    rstn = 1'b1; ce = 1'b0; wn = 1'b1; oam = 1'b0;
    dmc_addr = 16'h0000; rdata = 8'h00;
    req[0] = 1'b0; req[1] = 1'b0;
    #1 rstn = 1'b0;
    #1;
    check_reset(0);
    check_reset(1);
    repeat (2) tick();
    rstn = 1'b1;
    tick();

    run_xfer(0, 16'hC123, 0, 0, 0, 0);
    run_xfer(0, 16'($urandom), 2, 1, 0, 0);
    run_xfer(0, 16'($urandom), 10, 2, 0, 0);
    abort_halt(0);
    run_xfer(0, 16'($urandom), 1, 0, 1, 0);

    // Reset while the bus read is pending.
    a = 16'($urandom);
    dmc_addr = a; req[0] = 1'b1;
    tick();
    for (int j = 0; j < PV[0]; j++) begin
      wn = 1'b1; oam = 1'b0; rdata = 8'($urandom); ce = 1'b1;
      tick();
    end
    ce = 1'b0;
    check("pre_rst_own", own[0], 1);
    check("pre_rst_addr", baddr[0], a);
    #2 rstn = 1'b0;
    #1;
    check_reset(0);
    req[0] = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
    run_xfer(0, 16'($urandom), 0, 0, 0, 0);

    run_xfer(1, 16'($urandom), 0, 0, 0, 1);
    run_xfer(1, 16'($urandom), 0, 0, 0, 0);

    s = int'($urandom_range(0, 1));
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        abort_halt(s);
        s = int'($urandom_range(0, 1));
        continue;
      end
      drop  = (PV[s] > 1) && ($urandom_range(0, 4) == 0);
      keep  = !drop && (it < 29) && ($urandom_range(0, 2) == 0);
      nxt_s = keep ? s : int'($urandom_range(0, 1));
      run_xfer(s, 16'($urandom), int'($urandom_range(0, 4)),
               int'($urandom_range(0, 2)), drop, keep);
      s = nxt_s;
    end

    repeat (5) tick();
    check("q0_drained", exp_q0.size(), 0);
    check("q1_drained", exp_q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
